// File: rtl/fifo_arb.sv
// Round-robin arbiter that moves bounded bursts from NREQ requesters into one shared FIFO.
// Define FIFO_ARB_TAG_EN to prepend the grantee index (TW bits) to fifo_data_o.
module fifo_arb #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 32,
    parameter int MAXBURST = 4,
    localparam int TW      = (NREQ > 2) ? $clog2(NREQ) : 1,
`ifdef FIFO_ARB_TAG_EN
    localparam int OW      = DWIDTH + TW
`else
    localparam int OW      = DWIDTH
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ-1:0]          req_last_i,
    input  logic [NREQ*DWIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic [NREQ-1:0]          grant_o,
    output logic                     fifo_push_o,
    output logic [OW-1:0]            fifo_data_o,
    input  logic                     fifo_full_i,
    output logic                     busy_o
);

    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   grant, grant_nxt;
    logic [TW-1:0]     gidx, gidx_nxt;
    logic [TW-1:0]     rr_ptr, rr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [TW-1:0]     pick;
    logic              found;
    logic              busy, xfer, g_valid, g_last;
    logic [DWIDTH-1:0] data_sel;

    assign busy = (state == BURST);

    // The registered one-hot grant steers every per-requester mux.
    always_comb begin
        data_sel = '0;
        g_valid  = 1'b0;
        g_last   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                data_sel = req_data_i[k*DWIDTH +: DWIDTH];
                g_valid  = req_valid_i[k];
                g_last   = req_last_i[k];
            end
        end
    end

    assign xfer        = busy && g_valid && !fifo_full_i;
    assign fifo_push_o = xfer;
    assign req_ready_o = busy ? (grant & {NREQ{!fifo_full_i}}) : '0;
    assign grant_o     = grant;
    assign busy_o      = busy;

`ifdef FIFO_ARB_TAG_EN
    assign fifo_data_o = busy ? {gidx, data_sel} : '0;
`else
    assign fifo_data_o = busy ? data_sel : '0;
`endif

    // Two passes give the first requester at or above rr_ptr, then wrap to the bottom.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid_i[k] && (TW'(k) >= rr_ptr)) begin
                found = 1'b1;
                pick  = TW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid_i[k]) begin
                found = 1'b1;
                pick  = TW'(k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        rr_nxt    = rr_ptr;
        cnt_inc   = cnt + 1'b1;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BURST;
                    grant_nxt = NREQ'(1) << pick;
                    gidx_nxt  = pick;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_nxt = cnt_inc;
                    // A full count releases the grant even when last is never raised.
                    if (g_last || (cnt_inc == CW'(MAXBURST))) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        gidx_nxt  = '0;
                        cnt_nxt   = '0;
                        rr_nxt    = (gidx == TW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            gidx   <= gidx_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_arb.sv
// Scoreboard bench for fifo_arb: per-requester beat sources, expected pushes and grants in queues.
// Compile with FIFO_ARB_TAG_EN to also check the grantee tag on fifo_data_o.
module tb_fifo_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
`ifdef FIFO_ARB_TAG_EN
    localparam int OW = DW + 2;
`else
    localparam int OW = DW;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
    logic [NREQ*DW-1:0] req_data;
    logic              fifo_push, fifo_full, busy;
    logic [OW-1:0]     fifo_data;

    always #5 clk = ~clk;

    fifo_arb #(.NREQ(NREQ), .DWIDTH(DW), .MAXBURST(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .fifo_push_o (fifo_push),
        .fifo_data_o (fifo_data),
        .fifo_full_i (fifo_full),
        .busy_o      (busy)
    );

    logic [31:0] src_data [4][16];
    logic        src_last [4][16];
    int          src_len  [4];
    int          src_pos  [4];

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (src_pos[k] < src_len[k] && src_pos[k] < 16) begin
                req_valid[k]         = 1'b1;
                req_last[k]          = src_last[k][src_pos[k][3:0]];
                req_data[k*DW +: DW] = src_data[k][src_pos[k][3:0]];
            end
        end
    end

    logic [33:0]     exp_push [$];
    int              exp_grant [$];
    int              checks = 0;
    int              errors = 0;
    int              pushes = 0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int idx, input logic [31:0] d);
        logic [1:0] t;
        t = idx[1:0];
        exp_push.push_back({t, d});
    endtask

    task automatic load(input int k, input logic [31:0] d0, input int n,
                        input bit last_all, input bit last_end);
        for (int i = 0; i < n; i++) begin
            src_data[k][i] = d0 + i;
            src_last[k][i] = last_all || (last_end && i == n - 1);
        end
        src_pos[k] = 0;
        src_len[k] = n;
    endtask

    task automatic monitor();
        logic [33:0] e;
        if (fifo_push) begin
            pushes++;
            if (exp_push.size() == 0) begin
                check("push_extra", exp_push.size(), 1);
            end else begin
                e = exp_push.pop_front();
`ifdef FIFO_ARB_TAG_EN
                check("push_data", fifo_data, e);
`else
                check("push_data", fifo_data, e[31:0]);
`endif
            end
        end
        if (grant != prev_grant && grant != 0) begin
            check("bubble", prev_grant, 0);
            if (exp_grant.size() == 0)
                check("grant_extra", exp_grant.size(), 1);
            else
                check("grant", grant, 4'b0001 << exp_grant.pop_front());
        end
        if (fifo_full) begin
            check("full_push", fifo_push, 0);
            check("full_ready", req_ready, 0);
        end
        if (!busy)
            check("idle_out", {fifo_push, req_ready, grant, fifo_data}, 0);
        else
            check("busy_onehot", $onehot(grant), 1);
        prev_grant = grant;
    endtask

    // Sample mid-cycle, then advance each source whose beat was accepted at the edge.
    task automatic step();
        logic [NREQ-1:0] fire;
        @(negedge clk);
        monitor();
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++)
                if (fire[k]) src_pos[k]++;
        end
    endtask

    task automatic drain(input int budget, input bit need_idle);
        int n;
        n = 0;
        while ((exp_push.size() > 0 || exp_grant.size() > 0 || (need_idle && busy)) && n < budget) begin
            step();
            n++;
        end
        check("drain_push", exp_push.size(), 0);
        check("drain_grant", exp_grant.size(), 0);
        repeat (2) step();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_push", fifo_push, 0);
        check("rst_ready", req_ready, 0);
        check("rst_data", fifo_data, 0);
        rst_n = 1'b1;

        // Two requesters, single-beat bursts: alternate with an idle cycle between.
        load(0, 32'h100, 2, 1, 1);
        load(2, 32'h200, 2, 1, 1);
        exp_grant.push_back(0); exp_grant.push_back(2);
        exp_grant.push_back(0); exp_grant.push_back(2);
        sb_push(0, 32'h100); sb_push(2, 32'h200);
        sb_push(0, 32'h101); sb_push(2, 32'h201);
        drain(60, 1);

        // Six beats without last: forced release after four, regrant for the rest, then hold.
        load(1, 32'hA0, 6, 0, 0);
        exp_grant.push_back(1); exp_grant.push_back(1);
        for (int i = 0; i < 6; i++) sb_push(1, 32'hA0 + i);
        drain(60, 0);
        repeat (3) step();
        check("hold_busy", busy, 1);
        check("hold_grant", grant, 4'b0010);
        check("hold_push", fifo_push, 0);
        src_data[1][6] = 32'hA6;
        src_last[1][6] = 1'b1;
        src_len[1]     = 7;
        sb_push(1, 32'hA6);
        drain(60, 1);

        // FIFO full for three cycles in the middle of requester 3's burst.
        load(3, 32'hC0, 6, 0, 1);
        load(0, 32'hD0, 1, 1, 1);
        exp_grant.push_back(3); exp_grant.push_back(0); exp_grant.push_back(3);
        for (int i = 0; i < 4; i++) sb_push(3, 32'hC0 + i);
        sb_push(0, 32'hD0);
        sb_push(3, 32'hC4); sb_push(3, 32'hC5);
        pushes = 0;
        n = 0;
        while (pushes < 2 && n < 40) begin
            step();
            n++;
        end
        fifo_full = 1'b1;
        repeat (3) step();
        fifo_full = 1'b0;
        drain(60, 1);

        // Move the pointer to 2, then all four requesters at once.
        load(1, 32'hE0, 1, 1, 1);
        exp_grant.push_back(1);
        sb_push(1, 32'hE0);
        drain(40, 1);
        for (int k = 0; k < NREQ; k++) load(k, 32'hF000_0000 + k, 1, 1, 1);
        exp_grant.push_back(2); exp_grant.push_back(3);
        exp_grant.push_back(0); exp_grant.push_back(1);
        sb_push(2, 32'hF000_0002); sb_push(3, 32'hF000_0003);
        sb_push(0, 32'hF000_0000); sb_push(1, 32'hF000_0001);
        drain(60, 1);

        // Asynchronous reset pulse during the second beat; arbitration restarts at requester 0.
        load(2, 32'h60, 4, 0, 1);
        load(0, 32'h70, 1, 1, 1);
        exp_grant.push_back(2); exp_grant.push_back(0); exp_grant.push_back(2);
        sb_push(2, 32'h60); sb_push(0, 32'h70);
        sb_push(2, 32'h61); sb_push(2, 32'h62); sb_push(2, 32'h63);
        pushes = 0;
        n = 0;
        while (pushes < 1 && n < 40) begin
            step();
            n++;
        end
        #1;
        check("pre_rst_push", fifo_push, 1);
        rst_n = 1'b0;
        #1;
        check("rst_pulse_push", fifo_push, 0);
        check("rst_pulse_grant", grant, 0);
        check("rst_pulse_ready", req_ready, 0);
        rst_n = 1'b1;
        check("rst_rel_busy", busy, 0);
        drain(60, 1);

        // Grantee 2 carries its index as the tag when tagging is enabled.
        load(2, 32'h1234_5678, 1, 1, 1);
        exp_grant.push_back(2);
        sb_push(2, 32'h1234_5678);
        drain(40, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
